masked_demask: RTL and testbench
================================

MASKED_DEMASK -- requirements
Module: masked_demask

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 2, meaning number of Boolean shares; legal values 2..5.
REQ-002 SHALL have parameter BIT_WIDTH, default 2, meaning bits per share.
REQ-003 SHALL have port in_clock, input, 1, the single clock.
REQ-004 SHALL have port in_reset, input, 1; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port in_shares, input, NUM_SHARES x BIT_WIDTH, the masked operand.
REQ-006 SHALL have port in_valid, input, 1, meaning in_shares is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts in_shares this cycle.
REQ-008 SHALL have port out_value, output, BIT_WIDTH, the unmasked result.
REQ-009 SHALL have port out_valid, output, 1, meaning out_value is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes out_value.
REQ-011 SHALL have port in_random, input, num_zero_random(NUM_SHARES) x BIT_WIDTH, present only when DEMASK_REFRESH_EN is defined.

Function
REQ-012 SHALL implement FSM states IDLE, REFRESH (macro only), FOLD and DONE.
REQ-013 IDLE: in_ready=1. On in_valid&in_ready, latch in_shares into a share register, clear the accumulator and the fold index, and go to REFRESH (macro defined) or FOLD (macro undefined).
REQ-014 REFRESH: lasts one cycle; share register ^= registered masked-zero vector; go to FOLD.
REQ-015 FOLD: each cycle, acc ^= share_reg[idx] and idx++. When idx == NUM_SHARES-1, go to DONE.
REQ-016 Shares SHALL be folded strictly one per cycle, in index order, never combined combinationally.
REQ-017 DONE: out_valid=1 and out_value=acc. On out_ready, go to IDLE and zero both the share register and the accumulator in the same edge.
REQ-018 out_valid SHALL rise exactly NUM_SHARES edges after the accepting edge, or NUM_SHARES+1 with the macro.
REQ-019 in_ready SHALL be 0 in every state except IDLE; there is no overlap of transactions.
REQ-020 With out_ready low in DONE, the block SHALL hold state, and out_value SHALL stay stable.
REQ-021 out_value SHALL be all-zero whenever out_valid=0.
REQ-022 The fold index SHALL be ceil(log2(NUM_SHARES)) bits wide and SHALL never exceed NUM_SHARES-1.

Reset
REQ-023 When in_reset is sampled high, the block SHALL enter IDLE and zero the share register, accumulator, index and masked-zero register.
REQ-024 Reset values SHALL be in_ready=1, out_valid=0 and out_value=0.
REQ-025 Reset mid-transaction SHALL drop the transaction silently and produce no output.

Configuration
REQ-026 Macro DEMASK_REFRESH_EN defined: in_random exists, the REFRESH state exists, the masked_zero instance exists, and latency is NUM_SHARES+1.
REQ-027 Macro DEMASK_REFRESH_EN undefined: no in_random, no REFRESH, no randomness logic, and latency is NUM_SHARES.
REQ-028 With the macro defined, the unmasked result SHALL be identical to the result without it; the refresh only re-randomises the shares.

Structure
REQ-029 A state enum demask_state_t SHALL live in aes128_package; num_zero_random() SHALL be reused from that package.
REQ-030 The refresh SHALL instantiate one sub-module, masked_zero (NUM_SHARES, BIT_WIDTH), fed by in_random; its registered output is consumed in REFRESH.
REQ-031 Share and accumulator storage SHALL use the shared register module.

Verification
REQ-032 NUM_SHARES=3, BIT_WIDTH=8, shares {0x5A,0x3C,0x00}, macro off -> out_valid 3 edges after accept, out_value=0x66.
REQ-033 Same stimulus, macro on, random in_random each cycle -> out_value=0x66 after 4 edges; the share register differs from the input after REFRESH.
REQ-034 NUM_SHARES=2, shares {0xFF,0xFF}, out_ready held low for 5 cycles -> out_valid=1 and out_value=0x00 stable; in_ready=0; a second in_valid is ignored.
REQ-035 Reset asserted during FOLD of {0x12,0x34,0x56} -> next cycle in_ready=1, out_valid=0, out_value=0, and the share register reads zero.
REQ-036 NUM_SHARES=5, 100 random back-to-back transactions with out_ready=1 -> each out_value equals the XOR of its shares, with one idle cycle between transactions.

Source files
------------

// File: rtl/masked_demask_pkg.sv
// Shared types and helpers for the masked demask slice.
// DEMASK_REFRESH_EN adds the REFRESH state to the state enum.
package aes128_package;

`ifdef DEMASK_REFRESH_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REFRESH = 2'd1,
        ST_FOLD    = 2'd2,
        ST_DONE    = 2'd3
    } demask_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd2,
        ST_DONE = 2'd3
    } demask_state_t;
`endif

    // A chained masked zero needs one random word per adjacent share pair.
    function automatic int num_zero_random(input int num_shares);
        return num_shares - 1;
    endfunction

endpackage

// File: rtl/masked_demask_reg.sv
// Generic enabled storage register with synchronous active-high reset,
// used for the share, accumulator and masked-zero storage.
module masked_demask_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled; reset clears the stored value.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/masked_zero.sv
// Registered Boolean sharing of zero built from fresh random words; XORing it
// into a sharing re-randomises the shares without changing the secret.
module masked_zero
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [num_zero_random(NUM_SHARES)*BIT_WIDTH-1:0] random,
    output logic [NUM_SHARES*BIT_WIDTH-1:0]                  zero_shares
);
    localparam int NUM_RAND = num_zero_random(NUM_SHARES);

    logic [NUM_SHARES*BIT_WIDTH-1:0] zero_s;

    // Each random word lands in two adjacent shares so the XOR of all shares cancels.
    always_comb begin
        zero_s = '0;
        for (int i = 0; i < NUM_RAND; i++) begin
            zero_s[i*BIT_WIDTH +: BIT_WIDTH]     = zero_s[i*BIT_WIDTH +: BIT_WIDTH] ^ random[i*BIT_WIDTH +: BIT_WIDTH];
            zero_s[(i+1)*BIT_WIDTH +: BIT_WIDTH] = random[i*BIT_WIDTH +: BIT_WIDTH];
        end
    end

    masked_demask_reg #(.WIDTH(NUM_SHARES*BIT_WIDTH)) u_zero_reg (
        .clock  (clock),
        .reset  (reset),
        .enable (1'b1),
        .d      (zero_s),
        .q      (zero_shares)
    );

endmodule

// File: rtl/masked_demask.sv
// Folds NUM_SHARES Boolean shares into the unmasked value, one share per cycle.
// Define DEMASK_REFRESH_EN to re-randomise the shares for one cycle before folding.
module masked_demask
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
) (
    input  logic                                             in_clock,
    input  logic                                             in_reset,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]                  in_shares,
    input  logic                                             in_valid,
    output logic                                             in_ready,
`ifdef DEMASK_REFRESH_EN
    input  logic [num_zero_random(NUM_SHARES)*BIT_WIDTH-1:0] in_random,
`endif
    output logic [BIT_WIDTH-1:0]                             out_value,
    output logic                                             out_valid,
    input  logic                                             out_ready
);
    localparam int                SHARE_W  = NUM_SHARES * BIT_WIDTH;
    localparam int                IDX_W    = $clog2(NUM_SHARES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SHARES - 1);

    demask_state_t        state_r;
    logic [IDX_W-1:0]     idx_r;
    logic [SHARE_W-1:0]   share_r;
    logic [SHARE_W-1:0]   share_d_s;
    logic                 share_en_s;
    logic [BIT_WIDTH-1:0] acc_r;
    logic [BIT_WIDTH-1:0] acc_d_s;
    logic                 acc_en_s;
    logic [BIT_WIDTH-1:0] fold_s;
    logic                 accept_s;

    assign accept_s = in_valid & in_ready;
    assign fold_s   = acc_r ^ share_r[idx_r*BIT_WIDTH +: BIT_WIDTH];

`ifdef DEMASK_REFRESH_EN
    logic [SHARE_W-1:0] zero_r;

    masked_zero #(.NUM_SHARES(NUM_SHARES), .BIT_WIDTH(BIT_WIDTH)) u_masked_zero (
        .clock       (in_clock),
        .reset       (in_reset),
        .random      (in_random),
        .zero_shares (zero_r)
    );
`endif

    // Next-value and enable selection for the share and accumulator registers.
    always_comb begin
        share_en_s = 1'b0;
        share_d_s  = '0;
        acc_en_s   = 1'b0;
        acc_d_s    = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    share_en_s = 1'b1;
                    share_d_s  = in_shares;
                    acc_en_s   = 1'b1;
                end else begin
                    share_en_s = 1'b0;
                end
            end
`ifdef DEMASK_REFRESH_EN
            ST_REFRESH: begin
                share_en_s = 1'b1;
                share_d_s  = share_r ^ zero_r;
            end
`endif
            ST_FOLD: begin
                acc_en_s = 1'b1;
                acc_d_s  = fold_s;
            end
            ST_DONE: begin
                if (out_ready) begin
                    share_en_s = 1'b1;
                    acc_en_s   = 1'b1;
                end else begin
                    acc_en_s = 1'b0;
                end
            end
            default: begin
                share_en_s = 1'b0;
            end
        endcase
    end

    masked_demask_reg #(.WIDTH(SHARE_W)) u_share_reg (
        .clock  (in_clock),
        .reset  (in_reset),
        .enable (share_en_s),
        .d      (share_d_s),
        .q      (share_r)
    );

    masked_demask_reg #(.WIDTH(BIT_WIDTH)) u_acc_reg (
        .clock  (in_clock),
        .reset  (in_reset),
        .enable (acc_en_s),
        .d      (acc_d_s),
        .q      (acc_r)
    );

    // Control FSM; out_value is loaded with the final fold so it is stable through DONE.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_value <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        idx_r    <= '0;
                        in_ready <= 1'b0;
`ifdef DEMASK_REFRESH_EN
                        state_r  <= ST_REFRESH;
`else
                        state_r  <= ST_FOLD;
`endif
                    end
                end
`ifdef DEMASK_REFRESH_EN
                ST_REFRESH: begin
                    state_r <= ST_FOLD;
                end
`endif
                ST_FOLD: begin
                    if (idx_r == LAST_IDX) begin
                        state_r   <= ST_DONE;
                        out_valid <= 1'b1;
                        out_value <= fold_s;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r   <= ST_IDLE;
                        idx_r     <= '0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_value <= '0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    idx_r     <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_value <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_demask.sv
// Self-checking bench for masked_demask: table-driven vectors on a 3-share
// instance, hold/back-pressure on 2 shares, and random traffic on 5 shares.
module tb_masked_demask;
`ifdef DEMASK_REFRESH_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct {
        logic [23:0] shares;
        logic [7:0]  value;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [23:0] sh3;
    logic        v3, rdy3, ov3, ordy3;
    logic [7:0]  val3;
    logic [15:0] sh2;
    logic        v2, rdy2, ov2, ordy2;
    logic [7:0]  val2;
    logic [39:0] sh5;
    logic        v5, rdy5, ov5, ordy5;
    logic [7:0]  val5;

    logic [7:0] q3[$];
    logic [7:0] q5[$];
    vec_t       vecs[6];

`ifdef DEMASK_REFRESH_EN
    logic [15:0] rnd3;
    logic [7:0]  rnd2;
    logic [31:0] rnd5;

    initial begin
        rnd3 = '0;
        rnd2 = '0;
        rnd5 = '0;
        forever begin
            @(negedge clk);
            rnd3 = 16'($urandom);
            rnd2 = 8'($urandom);
            rnd5 = $urandom;
        end
    end
`endif

    masked_demask #(.NUM_SHARES(3), .BIT_WIDTH(8)) u3 (
        .in_clock(clk), .in_reset(rst), .in_shares(sh3), .in_valid(v3), .in_ready(rdy3),
`ifdef DEMASK_REFRESH_EN
        .in_random(rnd3),
`endif
        .out_value(val3), .out_valid(ov3), .out_ready(ordy3)
    );

    masked_demask #(.NUM_SHARES(2), .BIT_WIDTH(8)) u2 (
        .in_clock(clk), .in_reset(rst), .in_shares(sh2), .in_valid(v2), .in_ready(rdy2),
`ifdef DEMASK_REFRESH_EN
        .in_random(rnd2),
`endif
        .out_value(val2), .out_valid(ov2), .out_ready(ordy2)
    );

    masked_demask #(.NUM_SHARES(5), .BIT_WIDTH(8)) u5 (
        .in_clock(clk), .in_reset(rst), .in_shares(sh5), .in_valid(v5), .in_ready(rdy5),
`ifdef DEMASK_REFRESH_EN
        .in_random(rnd5),
`endif
        .out_value(val5), .out_valid(ov5), .out_ready(ordy5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [7:0] xor5(input logic [39:0] s);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 5; i++) r = r ^ s[i*8 +: 8];
        return r;
    endfunction

    // One full transaction on the 3-share instance, checking latency and handshake.
    task automatic txn3(input logic [23:0] sh, input logic [7:0] exp_v, input int tag);
        int cyc;
        chk($sformatf("t%0d in_ready idle", tag), {31'd0, rdy3}, 32'd1);
        sh3 = sh;
        v3  = 1'b1;
        q3.push_back(exp_v);
        @(negedge clk);
        v3  = 1'b0;
        cyc = 0;
        chk($sformatf("t%0d in_ready busy", tag), {31'd0, rdy3}, 32'd0);
`ifdef DEMASK_REFRESH_EN
        @(negedge clk);
        cyc = 1;
        chk($sformatf("t%0d refresh changed shares", tag), {31'd0, (u3.share_r != sh)}, 32'd1);
`endif
        while (!ov3 && cyc < 20) begin
            chk($sformatf("t%0d out_value zero while invalid", tag), {24'd0, val3}, 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("t%0d latency", tag), cyc, 32'(3 + EXTRA));
        if (ov3 && q3.size() > 0) begin
            chk($sformatf("t%0d out_value", tag), {24'd0, val3}, {24'd0, q3.pop_front()});
        end else begin
            chk($sformatf("t%0d out_valid seen", tag), {31'd0, ov3}, 32'd1);
        end
        @(negedge clk);
        chk($sformatf("t%0d back to idle", tag), {29'd0, rdy3, ov3, |val3}, 32'd4);
    endtask

    // Advance one cycle on the 5-share instance and score any produced output.
    task automatic tick5();
        @(negedge clk);
        if (ov5) begin
            if (q5.size() == 0) chk("u5 unexpected output", {31'd0, ov5}, 32'd0);
            else chk("u5 out_value", {24'd0, val5}, {24'd0, q5.pop_front()});
        end else begin
            chk("u5 zero when invalid", {24'd0, val5}, 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int w;
        logic [63:0] r64;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        sh3 = '0; v3 = 1'b0; ordy3 = 1'b1;
        sh2 = '0; v2 = 1'b0; ordy2 = 1'b0;
        sh5 = '0; v5 = 1'b0; ordy5 = 1'b1;

        vecs[0] = '{24'h003C5A, 8'h66};
        vecs[1] = '{24'hFFFFFF, 8'hFF};
        vecs[2] = '{24'h000000, 8'h00};
        vecs[3] = '{24'h040201, 8'h07};
        vecs[4] = '{24'h0055AA, 8'hFF};
        vecs[5] = '{24'h563412, 8'h70};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset u3 in_ready",  {31'd0, rdy3}, 32'd1);
        chk("reset u3 out_valid", {31'd0, ov3},  32'd0);
        chk("reset u3 out_value", {24'd0, val3}, 32'd0);
        chk("reset u5 in_ready",  {31'd0, rdy5}, 32'd1);
        chk("reset u2 out_valid", {31'd0, ov2},  32'd0);

        for (int i = 0; i < 6; i++) txn3(vecs[i].shares, vecs[i].value, i);

        // Reset in the middle of folding drops the transaction.
        sh3 = 24'h563412;
        v3  = 1'b1;
        @(negedge clk);
        v3 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst in_ready",  {31'd0, rdy3}, 32'd1);
        chk("midrst out_valid", {31'd0, ov3},  32'd0);
        chk("midrst out_value", {24'd0, val3}, 32'd0);
        chk("midrst share reg", {8'd0, u3.share_r}, 32'd0);
        chk("midrst acc reg",   {24'd0, u3.acc_r},  32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("midrst no output", {31'd0, ov3}, 32'd0);
        end

        // Back-pressure hold on the 2-share instance; a second request is ignored.
        sh2 = 16'hFFFF;
        v2  = 1'b1;
        @(negedge clk);
        v2  = 1'b0;
        cyc = 0;
        while (!ov2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("u2 latency", cyc, 32'(2 + EXTRA));
        sh2 = 16'h0201;
        v2  = 1'b1;
        repeat (5) begin
            chk("hold out_valid", {31'd0, ov2},  32'd1);
            chk("hold out_value", {24'd0, val2}, 32'd0);
            chk("hold in_ready",  {31'd0, rdy2}, 32'd0);
            @(negedge clk);
        end
        v2    = 1'b0;
        ordy2 = 1'b1;
        @(negedge clk);
        chk("hold release in_ready",  {31'd0, rdy2}, 32'd1);
        chk("hold release out_valid", {31'd0, ov2},  32'd0);
        repeat (5) begin
            @(negedge clk);
            chk("ignored request no output", {31'd0, ov2}, 32'd0);
        end

        // Back-to-back random traffic on the 5-share instance.
        r64 = {$urandom, $urandom};
        sh5 = r64[39:0];
        v5  = 1'b1;
        for (int t = 0; t < 100; t++) begin
            w = 0;
            while (!rdy5 && w < 50) begin
                tick5();
                w++;
            end
            if (t > 0) chk("u5 accept spacing", w, 32'(6 + EXTRA));
            q5.push_back(xor5(sh5));
            tick5();
            r64 = {$urandom, $urandom};
            sh5 = r64[39:0];
        end
        v5 = 1'b0;
        w  = 0;
        while (q5.size() > 0 && w < 50) begin
            tick5();
            w++;
        end
        chk("u5 scoreboard drained", q5.size(), 32'd0);
        chk("u3 scoreboard drained", q3.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
